// File: rtl/lsu_access_ctrl.sv
// Load/store access controller between the EXU and the data-memory port.
// Word-aligned requests with byte lanes; aligned and extended load results.
module lsu_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [2:0]            in_op,
  input  logic                  in_ren,
  input  logic                  in_wen,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic [1:0]            out_err
);

  localparam int          DW = DATA_WIDTH;
  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_ACC = 2'b01;
  localparam logic [1:0] ERR_BUS = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_we;
  logic [DW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [3:0]      r_wmask;
  logic [2:0]      r_op;
  logic [15:0]     r_cnt;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_err;

  logic            w_ldst;
  logic            w_illegal;
  logic            w_misal;
  logic            w_bad;
  logic            w_to;
  logic [3:0]      w_wmask;
  logic [DW-1:0]   w_wdata_sh;
  logic [DW-1:0]   w_rsh;
  logic [DW-1:0]   w_ld;
  logic            w_idle;
  logic            w_req;
  logic            w_resp;

  assign w_ldst     = in_ren | in_wen;
  assign w_bad      = w_illegal | w_misal;
  assign w_wdata_sh = in_wdata << {in_addr[1:0], 3'b000};
  assign w_rsh      = mem_rdata >> {r_addr[1:0], 3'b000};
  assign w_to       = (r_cnt + 16'd1) == TO;

  // Legality and alignment check of the incoming request
  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    if (in_ren && in_wen) begin
      w_illegal = 1'b1;
    end else if (in_wen) begin
      w_illegal = !(in_op == OP_B || in_op == OP_H ||
                    in_op == OP_W);
    end else if (in_ren) begin
      w_illegal = !(in_op == OP_B  || in_op == OP_H  ||
                    in_op == OP_W  || in_op == OP_BU ||
                    in_op == OP_HU);
    end
    case (in_op[1:0])
      2'b01:   w_misal = in_addr[0];
      2'b10:   w_misal = in_addr[1:0] != 2'b00;
      default: w_misal = 1'b0;
    endcase
  end

  // Byte-lane write mask for stores
  always_comb begin
    w_wmask = 4'b0000;
    if (in_wen) begin
      case (in_op[1:0])
        2'b00:   w_wmask = 4'b0001 << in_addr[1:0];
        2'b01:   w_wmask = 4'b0011 << in_addr[1:0];
        2'b10:   w_wmask = 4'b1111;
        default: w_wmask = 4'b0000;
      endcase
    end
  end

  // Load data extraction and extension
  always_comb begin
    w_ld = w_rsh;
    case (r_op)
      OP_B:    w_ld = {{24{w_rsh[7]}}, w_rsh[7:0]};
      OP_BU:   w_ld = {24'd0, w_rsh[7:0]};
      OP_H:    w_ld = {{16{w_rsh[15]}}, w_rsh[15:0]};
      OP_HU:   w_ld = {16'd0, w_rsh[15:0]};
      default: w_ld = w_rsh;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = (w_ldst && !w_bad) ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (mem_ack || w_to) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, timeout counting and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_we    <= in_wen;
            r_addr  <= in_addr;
            r_wdata <= w_wdata_sh;
            r_wmask <= w_wmask;
            r_op    <= in_op;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= (w_ldst && w_bad) ? ERR_ACC : ERR_OK;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_rdata <= r_we ? '0 : w_ld;
            r_err   <= ERR_OK;
          end else if (w_to) begin
            r_rdata <= '0;
            r_err   <= ERR_BUS;
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_idle = !rst && (r_state == S_IDLE);
  assign w_req  = !rst && (r_state == S_REQ);
  assign w_resp = !rst && (r_state == S_RESP);

  assign in_ready  = w_idle;
  assign mem_req   = w_req;
  assign mem_we    = w_req & r_we;
  assign mem_addr  = w_req ? {r_addr[DW-1:2], 2'b00} : '0;
  assign mem_wdata = (w_req && r_we) ? r_wdata : '0;
  assign mem_wmask = (w_req && r_we) ? r_wmask : 4'b0000;
  assign out_valid = w_resp;
  assign out_rdata = w_resp ? r_rdata : '0;
  assign out_err   = w_resp ? r_err : ERR_OK;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Bench for lsu_access_ctrl: directed cases plus random
// transactions against a behavioural reference model.
module tb_lsu_access_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [2:0]  in_op = '0;
  logic        in_ren = 1'b0;
  logic        in_wen = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;

  int total = 0;
  int bad   = 0;

  lsu_access_ctrl #(
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_wdata(in_wdata),
    .in_op(in_op),
    .in_ren(in_ren),
    .in_wen(in_wen),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_rdata(out_rdata),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // What the request should turn into, from the access rules
  function automatic void ref_req(
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [2:0]  op,
    input  logic        ren,
    input  logic        wen,
    output logic        to_mem,
    output logic [1:0]  err,
    output logic [3:0]  mask,
    output logic [31:0] mwd
  );
    int nb;
    int s;
    bit legal;
    s      = int'(a % 4);
    nb     = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    to_mem = 1'b0;
    err    = 2'd0;
    mask   = 4'd0;
    mwd    = 32'd0;
    if (!ren && !wen) return;
    if (ren && wen)  legal = 1'b0;
    else if (wen)    legal = (op == 0 || op == 1 || op == 2);
    else             legal = (op == 0 || op == 1 || op == 2 ||
                              op == 4 || op == 5);
    if (!legal || (a % nb) != 0) begin
      err = 2'd1;
      return;
    end
    to_mem = 1'b1;
    if (wen) begin
      mask = 4'(((1 << nb) - 1) << s);
      mwd  = wd << (8 * s);
    end
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd,
                                           input logic [31:0] a,
                                           input logic [2:0]  op);
    logic [31:0] r;
    longint v;
    r = rd >> (8 * (a % 4));
    case (op)
      3'd0, 3'd4: begin
        v = longint'(r % 256);
        if (op == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = longint'(r % 65536);
        if (op == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(r);
    endcase
    return 32'(v);
  endfunction

  // One full transaction; ack_dly<0 or >=T means no ack
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] op, input logic ren,
                        input logic wen, input int ack_dly,
                        input logic [31:0] rd, input int hold);
    logic        tm;
    logic [1:0]  e;
    logic [3:0]  m;
    logic [31:0] w;
    logic [31:0] exp_rd;
    logic [1:0]  exp_err;
    ref_req(a, wd, op, ren, wen, tm, e, m, w);
    chk("rdy_idle", in_ready, 1);
    in_valid = 1'b1;
    in_addr  = a;
    in_wdata = wd;
    in_op    = op;
    in_ren   = ren;
    in_wen   = wen;
    @(negedge clk);
    in_valid = 1'b0;
    in_ren   = 1'b0;
    in_wen   = 1'b0;
    exp_rd   = 32'd0;
    exp_err  = e;
    if (tm) begin
      for (int k = 0; k < T; k++) begin
        chk("req", mem_req, 1);
        chk("rdy_req", in_ready, 0);
        chk("maddr", mem_addr, {a[31:2], 2'b00});
        chk("mwe", mem_we, wen);
        chk("mmask", mem_wmask, m);
        if (wen) chk("mwdata", mem_wdata, w);
        if (k == ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (k == ack_dly) break;
      end
      if (ack_dly >= 0 && ack_dly < T) begin
        exp_err = 2'd0;
        exp_rd  = ren ? ref_load(rd, a, op) : 32'd0;
      end else begin
        exp_err = 2'd2;
        exp_rd  = 32'd0;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      chk("oval", out_valid, 1);
      chk("oerr", out_err, exp_err);
      chk("ordata", out_rdata, exp_rd);
      chk("req_off", mem_req, 0);
      chk("rdy_resp", in_ready, 0);
      if (h < hold) begin
        mem_ack   = (h % 2) == 0;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack   = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("oval_off", out_valid, 0);
    chk("rdy_back", in_ready, 1);
  endtask

  initial begin
    logic [2:0]  op;
    logic        ren;
    logic        wen;
    int          sel;
    int          d;
    logic [2:0]  ops [8];
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd0};

    // reset with a pending request
    in_valid = 1'b1;
    in_ren   = 1'b1;
    in_op    = 3'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_rdy", in_ready, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_oval", out_valid, 0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    in_ren   = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", in_ready, 1);
    chk("post_rst_req", mem_req, 0);

    // store byte in top lane
    do_txn(32'h8000_0003, 32'h0000_00A5, 3'd0, 1'b0, 1'b1, 0, 0, 0);
    // signed and unsigned halfword loads
    do_txn(32'h8000_0002, 32'h0, 3'd1, 1'b1, 1'b0, 0,
           32'h8123_4567, 0);
    do_txn(32'h8000_0002, 32'h0, 3'd5, 1'b1, 1'b0, 0,
           32'h8123_4567, 0);
    // misaligned word load, held result
    do_txn(32'h8000_0001, 32'h0, 3'd2, 1'b1, 1'b0, 0, 0, 4);
    // bus timeout, late acks in RESP
    do_txn(32'h8000_0010, 32'h0, 3'd2, 1'b1, 1'b0, -1, 0, 3);
    // ack on the last permitted cycle
    do_txn(32'h8000_0011, 32'h0, 3'd4, 1'b1, 1'b0, T - 1,
           32'h0000_F000, 0);
    // no-op and illegal combinations
    do_txn(32'h8000_0000, 32'h0, 3'd2, 1'b0, 1'b0, 0, 0, 1);
    do_txn(32'h8000_0000, 32'h0, 3'd2, 1'b1, 1'b1, 0, 0, 0);
    do_txn(32'h8000_0000, 32'h0, 3'd4, 1'b0, 1'b1, 0, 0, 0);

    // reset while in REQ, then a stray ack
    in_valid = 1'b1;
    in_addr  = 32'h0000_0100;
    in_op    = 3'd2;
    in_ren   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_ren   = 1'b0;
    chk("rq_req", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rq_req_drop", mem_req, 0);
    chk("rq_oval", out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rq_rdy", in_ready, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rq_no_oval", out_valid, 0);
    chk("rq_no_req", mem_req, 0);
    chk("rq_rdy2", in_ready, 1);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      op  = ($urandom_range(0, 9) == 0) ? 3'($urandom)
                                        : ops[$urandom_range(0, 7)];
      sel = $urandom_range(0, 9);
      ren = (sel <= 4) || (sel == 8);
      wen = (sel >= 5 && sel <= 8);
      d   = $urandom_range(0, 6);
      do_txn($urandom, $urandom, op, ren, wen, (d >= 5) ? -1 : d,
             $urandom, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
Load/store access controller between the EXU and the data-memory port. Accepts one load or store per valid/ready handshake. Converts it into a word-aligned memory request with byte-lane data and write mask, waits for the memory acknowledge, then aligns and extends read data. Returns a result or error to the WBU through a second valid/ready handshake. Performs misalignment checks and bus-timeout detection.

Parameters:
DATA_WIDTH, 32, data and address width (only 32 is supported)
TIMEOUT_CYCLES, 255, max REQ cycles without mem_ack before a bus error is raised (1..65535)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
in_valid  in  1  EXU request valid
in_ready  out  1  controller can accept a request
in_addr  in  32  byte address
in_wdata  in  32  store data, right-justified
in_op  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_ren  in  1  load request
in_wen  in  1  store request
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  1 = write
mem_addr  out  32  {addr[31:2],2'b00}
mem_wdata  out  32  lane-shifted store data
mem_wmask  out  4  byte enables, bit i = byte lane i
mem_ack  in  1  memory completion, single-cycle pulse
mem_rdata  in  32  word read data, valid with mem_ack
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts result
out_rdata  out  32  aligned, extended load data (0 for stores and errors)
out_err  out  2  00 ok, 01 misaligned/illegal, 10 bus timeout

Behaviour:
- States: IDLE, REQ, RESP. Reset forces IDLE on the next edge. All outputs are 0 while rst is high, including in_ready. Internal registers and the timeout counter are cleared.
- Reset mid-operation: mem_req drops on the reset edge. Any later mem_ack is ignored.
- IDLE: in_ready=1. The request is captured on in_valid&in_ready.
  - Illegal if in_ren&in_wen, or if the op is not legal for the direction. Stores allow only 000/001/010; loads allow 000/001/010/100/101.
  - Misaligned if H/HU has addr[0]=1, or W has addr[1:0]!=0.
  - Illegal or misaligned -> RESP with out_err=01, out_rdata=0, and no mem_req issued.
  - in_valid with in_ren=in_wen=0 -> RESP with out_err=00, out_rdata=0 (no-op).
  - Otherwise -> REQ.
- REQ: mem_req=1, in_ready=0. mem_we, mem_addr, mem_wdata and mem_wmask come from registers and stay stable for the whole state.
  - mem_ack in the first REQ cycle is legal.
  - On mem_ack -> RESP, capture the result, err=00.
  - Each REQ cycle without ack increments the counter. When the count reaches TIMEOUT_CYCLES -> RESP, err=10, rdata=0. mem_req is low from that edge.
- Store lanes: let s=addr[1:0].
  - mem_wdata = in_wdata << 8*s.
  - mem_wmask: B=0001<<s, H=0011<<s, W=1111.
  - For loads, mem_wmask=0 and mem_we=0.
- Load align: r = mem_rdata >> 8*s.
  - B sign-extends r[7:0]; BU zero-extends r[7:0].
  - H sign-extends r[15:0]; HU zero-extends r[15:0].
  - W passes r unchanged.
- RESP: out_valid=1, with out_rdata/out_err held stable until out_ready. On out_valid&out_ready -> IDLE, out_valid=0 next cycle.
- mem_ack while in IDLE or RESP is ignored.
- Latency: accept at edge N, mem_req high cycle N+1. Ack in cycle N+1 gives out_valid in cycle N+2. Peak throughput is one access per 3 cycles; there is no bypass.

Test Plan:
- Reset behaviour: hold rst 2 cycles with in_valid=1 -> in_ready=0, mem_req=0, out_valid=0. After release, in_ready=1 with state IDLE.
- Store byte: SB addr=0x80000003, wdata=0x000000A5 -> mem_addr=0x80000000, mem_wdata=0xA5000000, mem_wmask=1000, mem_we=1. Ack next cycle -> out_valid, err=00.
- Load halfword: LH addr=0x80000002, mem_rdata=0x8123_4567 -> out_rdata=0xFFFF8123. Same request with LHU -> 0x00008123. Zero-wait ack gives 3-cycle turnaround.
- Misaligned load: LW addr=0x80000001 -> mem_req never asserts, out_err=01, out_rdata=0. Hold out_ready=0 for 4 cycles -> outputs stable, in_ready=0.
- Bus timeout: TIMEOUT_CYCLES=4, load with no ack -> mem_req high exactly 4 cycles, then out_err=10. A late mem_ack in RESP is ignored.
- Reset in REQ: assert rst while mem_req=1 -> mem_req=0 next edge. Ack one cycle after reset release produces no out_valid.
